// File: rtl/cim_pkg.sv
// Shared types for the CIM row sequencer: line-drive modes and FSM states.
package cim_pkg;

   typedef enum logic [1:0] {
      MODE_WRITE = 2'b00,
      MODE_MAC   = 2'b01,
      MODE_MACB  = 2'b10,
      MODE_CAM   = 2'b11
   } mode_t;

   typedef enum logic [1:0] {
      IDLE,
      PRECH,
      ASSERT,
      DONE
   } state_t;

endpackage

// File: rtl/cim_row_sequencer_if.sv
// Controller-facing bus of the row sequencer: request, handshake and array line drive.
interface cim_row_sequencer_if #(
   parameter int unsigned ROWS = 16,
   parameter int unsigned AW   = $clog2(ROWS)
);
   logic            cs;
   logic            start;
   logic [1:0]      mode;
   logic [AW-1:0]   addr;
   logic [AW:0]     burst_len;
   logic [ROWS-1:0] data;
   logic            busy;
   logic            done;
   logic            prech_en;
   logic [ROWS-1:0] WL;
   logic [ROWS-1:0] WLB;
   logic [AW-1:0]   row_idx;

   modport master (
      output cs, start, mode, addr, burst_len, data,
      input  busy, done, prech_en, WL, WLB, row_idx
   );

   modport slave (
      input  cs, start, mode, addr, burst_len, data,
      output busy, done, prech_en, WL, WLB, row_idx
   );
endinterface

// File: rtl/cim_onehot_dec.sv
// Combinational AW-to-ROWS one-hot decoder, shared by row and column drivers.
module cim_onehot_dec #(
   parameter int unsigned AW   = 4,
   parameter int unsigned ROWS = 1 << AW
) (
   input  logic [AW-1:0]   idx,
   output logic [ROWS-1:0] oh
);
   always_comb begin
      oh      = '0;
      oh[idx] = 1'b1;
   end
endmodule

// File: rtl/cim_row_sequencer.sv
// Row sequencer: precharge / word-line pulse timing with MAC bursts and CAM search drive.
module cim_row_sequencer
   import cim_pkg::*;
#(
   parameter int unsigned ROWS    = 16,
   parameter int unsigned AW      = $clog2(ROWS),
   parameter int unsigned PRECH_W = 1,
   parameter int unsigned PULSE_W = 2
) (
   input logic               clk,
   input logic               rst,
   cim_row_sequencer_if.slave bus
);
   localparam int unsigned CMAX = (PRECH_W > PULSE_W) ? PRECH_W : PULSE_W;
   localparam int unsigned CW   = (CMAX > 1) ? $clog2(CMAX) : 1;
   localparam logic [CW-1:0] PRECH_LD = CW'(PRECH_W - 1);
   localparam logic [CW-1:0] PULSE_LD = CW'(PULSE_W - 1);
   localparam logic [AW:0]   ROWS_L   = (AW + 1)'(ROWS);
   localparam logic [AW:0]   ONE_L    = (AW + 1)'(1);

   state_t          state_q, state_n;
   logic [CW-1:0]   cnt_q, cnt_n;
   logic [AW:0]     rem_q, rem_n;
   logic [AW-1:0]   row_q, row_n;
   mode_t           mode_q, mode_n;
   logic [ROWS-1:0] key_q, key_n;
   logic [AW:0]     len_clamped;
   logic [ROWS-1:0] oh_n;
   logic            busy_n, done_n, prech_n;
   logic [ROWS-1:0] wl_n, wlb_n;

   cim_onehot_dec #(.AW(AW), .ROWS(ROWS)) u_dec (
      .idx (row_n),
      .oh  (oh_n)
   );

   always_comb begin
      len_clamped = bus.burst_len;
      if (bus.burst_len == '0)
         len_clamped = ONE_L;
      else if (bus.burst_len > ROWS_L)
         len_clamped = ROWS_L;
   end

   always_comb begin
      state_n = state_q;
      cnt_n   = cnt_q;
      rem_n   = rem_q;
      row_n   = row_q;
      mode_n  = mode_q;
      key_n   = key_q;
      if (!bus.cs) begin
         state_n = IDLE;
         cnt_n   = '0;
         rem_n   = '0;
         row_n   = '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (bus.start) begin
                  state_n = PRECH;
                  cnt_n   = PRECH_LD;
                  row_n   = bus.addr;
                  mode_n  = mode_t'(bus.mode);
                  key_n   = bus.data;
                  // write and CAM get a count of one so the burst exit covers them too
                  if (mode_t'(bus.mode) == MODE_MAC || mode_t'(bus.mode) == MODE_MACB)
                     rem_n = len_clamped;
                  else
                     rem_n = ONE_L;
               end
            end
            PRECH: begin
               if (cnt_q == '0) begin
                  state_n = ASSERT;
                  cnt_n   = PULSE_LD;
               end else begin
                  cnt_n = cnt_q - CW'(1);
               end
            end
            ASSERT: begin
               if (cnt_q == '0) begin
                  rem_n = rem_q - ONE_L;
                  if (rem_n != '0) begin
                     state_n = PRECH;
                     cnt_n   = PRECH_LD;
                     row_n   = row_q + AW'(1);
                  end else begin
                     state_n = DONE;
                  end
               end else begin
                  cnt_n = cnt_q - CW'(1);
               end
            end
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
         endcase
      end
   end

   // Outputs are decoded from the next state so they appear registered in the same cycle as the state.
   always_comb begin
      busy_n  = (state_n == PRECH) || (state_n == ASSERT);
      done_n  = (state_n == DONE);
      prech_n = (state_n == PRECH);
      wl_n    = '0;
      wlb_n   = '0;
      if (state_n == ASSERT) begin
         case (mode_n)
            MODE_WRITE: begin
               wl_n  = oh_n;
               wlb_n = oh_n;
            end
            MODE_MAC:  wl_n  = oh_n;
            MODE_MACB: wlb_n = oh_n;
            MODE_CAM: begin
               wl_n  = key_n;
               wlb_n = ~key_n;
            end
            default: begin
               wl_n  = '0;
               wlb_n = '0;
            end
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= IDLE;
         cnt_q        <= '0;
         rem_q        <= '0;
         row_q        <= '0;
         mode_q       <= MODE_WRITE;
         key_q        <= '0;
         bus.busy     <= 1'b0;
         bus.done     <= 1'b0;
         bus.prech_en <= 1'b0;
         bus.WL       <= '0;
         bus.WLB      <= '0;
         bus.row_idx  <= '0;
      end else begin
         state_q      <= state_n;
         cnt_q        <= cnt_n;
         rem_q        <= rem_n;
         row_q        <= row_n;
         mode_q       <= mode_n;
         key_q        <= key_n;
         bus.busy     <= busy_n;
         bus.done     <= done_n;
         bus.prech_en <= prech_n;
         bus.WL       <= wl_n;
         bus.WLB      <= wlb_n;
         bus.row_idx  <= row_n;
      end
   end
endmodule

// File: tb/tb_cim_row_sequencer.sv
// Directed bench for cim_row_sequencer with ROWS=16, PRECH_W=1, PULSE_W=2.
module tb_cim_row_sequencer;
   logic clk;
   logic rst;
   int   total = 0;
   int   bad   = 0;

   cim_row_sequencer_if #(.ROWS(16), .AW(4)) bus ();

   cim_row_sequencer #(
      .ROWS    (16),
      .AW      (4),
      .PRECH_W (1),
      .PULSE_W (2)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic go(input logic [1:0] m, input logic [3:0] a, input logic [4:0] len,
                     input logic [15:0] d);
      bus.mode      = m;
      bus.addr      = a;
      bus.burst_len = len;
      bus.data      = d;
      bus.start     = 1'b1;
      tick();
      bus.start = 1'b0;
   endtask

   task automatic chk_idle(input string tag);
      chk({tag, "_busy"}, 32'(bus.busy), 32'd0);
      chk({tag, "_done"}, 32'(bus.done), 32'd0);
      chk({tag, "_prech"}, 32'(bus.prech_en), 32'd0);
      chk({tag, "_wl"}, 32'(bus.WL), 32'd0);
      chk({tag, "_wlb"}, 32'(bus.WLB), 32'd0);
   endtask

   initial begin
      logic [15:0] e;
      int          dcount, wlcnt, dcyc, viol;

      rst = 1'b1;
      bus.cs = 1'b0; bus.start = 1'b0; bus.mode = 2'b00;
      bus.addr = '0; bus.burst_len = '0; bus.data = '0;
      tick(); tick();
      chk_idle("reset");
      chk("reset_row", 32'(bus.row_idx), 32'd0);
      rst = 1'b0;
      bus.cs = 1'b1;
      tick(); tick();
      chk_idle("idle");

      // write, addr 5
      go(2'b00, 4'd5, 5'd3, 16'hFFFF);
      chk("wr_c1_prech", 32'(bus.prech_en), 32'd1);
      chk("wr_c1_busy", 32'(bus.busy), 32'd1);
      chk("wr_c1_wl", 32'(bus.WL), 32'd0);
      tick();
      chk("wr_c2_wl", 32'(bus.WL), 32'h0020);
      chk("wr_c2_wlb", 32'(bus.WLB), 32'h0020);
      chk("wr_c2_prech", 32'(bus.prech_en), 32'd0);
      chk("wr_c2_row", 32'(bus.row_idx), 32'd5);
      tick();
      chk("wr_c3_wl", 32'(bus.WL), 32'h0020);
      chk("wr_c3_wlb", 32'(bus.WLB), 32'h0020);
      tick();
      chk("wr_c4_done", 32'(bus.done), 32'd1);
      chk("wr_c4_busy", 32'(bus.busy), 32'd0);
      chk("wr_c4_wl", 32'(bus.WL), 32'd0);
      tick();
      chk("wr_c5_done", 32'(bus.done), 32'd0);

      // MAC burst wrapping 14,15,0,1
      go(2'b01, 4'd14, 5'd4, 16'h0000);
      for (int k = 0; k < 4; k++) begin
         e = 16'd1 << ((14 + k) % 16);
         chk("mac_prech", 32'(bus.prech_en), 32'd1);
         chk("mac_prech_wl", 32'(bus.WL), 32'd0);
         tick();
         chk("mac_wl_a", 32'(bus.WL), 32'(e));
         chk("mac_wlb_a", 32'(bus.WLB), 32'd0);
         chk("mac_row", 32'(bus.row_idx), 32'((14 + k) % 16));
         tick();
         chk("mac_wl_b", 32'(bus.WL), 32'(e));
         chk("mac_wlb_b", 32'(bus.WLB), 32'd0);
         chk("mac_done_early", 32'(bus.done), 32'd0);
         tick();
      end
      chk("mac_c13_done", 32'(bus.done), 32'd1);
      tick();
      chk("mac_c14_done", 32'(bus.done), 32'd0);

      // CAM search, data changed after start must not matter
      go(2'b11, 4'd0, 5'd7, 16'hA5C3);
      bus.data = 16'h0000;
      chk("cam_c1_prech", 32'(bus.prech_en), 32'd1);
      tick();
      chk("cam_c2_wl", 32'(bus.WL), 32'hA5C3);
      chk("cam_c2_wlb", 32'(bus.WLB), 32'h5A3C);
      tick();
      chk("cam_c3_wl", 32'(bus.WL), 32'hA5C3);
      chk("cam_c3_wlb", 32'(bus.WLB), 32'h5A3C);
      tick();
      chk("cam_c4_done", 32'(bus.done), 32'd1);
      tick();
      chk("cam_c5_done", 32'(bus.done), 32'd0);
      chk("cam_c5_busy", 32'(bus.busy), 32'd0);

      // MAC-bar abort during second row
      go(2'b10, 4'd0, 5'd4, 16'h0000);
      tick();
      chk("macb_r1_wlb", 32'(bus.WLB), 32'h0001);
      chk("macb_r1_wl", 32'(bus.WL), 32'd0);
      tick(); tick(); tick();
      chk("macb_r2_wlb", 32'(bus.WLB), 32'h0002);
      bus.cs = 1'b0;
      tick();
      chk_idle("abort");
      bus.cs = 1'b1;
      dcount = 0;
      for (int i = 0; i < 8; i++) begin
         tick();
         if (bus.done || bus.busy) dcount++;
      end
      chk("abort_no_done", 32'(dcount), 32'd0);

      // burst_len 0, start re-pulsed while busy and during DONE
      go(2'b01, 4'd3, 5'd0, 16'h0000);
      tick();
      chk("len0_wl", 32'(bus.WL), 32'h0008);
      bus.start = 1'b1;
      bus.addr  = 4'd9;
      tick();
      bus.start = 1'b0;
      chk("len0_c3_wl", 32'(bus.WL), 32'h0008);
      tick();
      chk("len0_c4_done", 32'(bus.done), 32'd1);
      bus.start = 1'b1;
      tick();
      bus.start = 1'b0;
      chk("done_start_ignored", 32'(bus.busy), 32'd0);
      dcount = 0;
      for (int i = 0; i < 8; i++) begin
         tick();
         if (bus.done || bus.busy) dcount++;
      end
      chk("len0_no_extra", 32'(dcount), 32'd0);

      // burst_len 31 clamps to 16 rows
      go(2'b01, 4'd0, 5'd31, 16'h0000);
      wlcnt = 0; dcount = 0; dcyc = 0; viol = 0;
      for (int c = 1; c <= 80; c++) begin
         if (bus.WL != '0) wlcnt++;
         if (bus.prech_en && ((bus.WL | bus.WLB) != '0)) viol++;
         if ($countones(bus.WL) > 1 || bus.WLB != '0) viol++;
         if (bus.done) begin
            dcount++;
            dcyc = c;
         end
         tick();
      end
      chk("clamp_wl_cycles", 32'(wlcnt), 32'd32);
      chk("clamp_done_count", 32'(dcount), 32'd1);
      chk("clamp_done_cycle", 32'(dcyc), 32'd49);
      chk("clamp_invariant", 32'(viol), 32'd0);

      // asynchronous reset mid-operation
      go(2'b01, 4'd0, 5'd2, 16'h0000);
      tick();
      chk("rstmid_wl", 32'(bus.WL), 32'h0001);
      #2 rst = 1'b1;
      #1;
      chk_idle("rstmid");
      tick();
      rst = 1'b0;
      dcount = 0;
      for (int i = 0; i < 10; i++) begin
         tick();
         if (bus.done || bus.busy) dcount++;
      end
      chk("rstmid_no_done", 32'(dcount), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/cim_row_sequencer.md
Name: cim_row_sequencer

Overview:
- Parametrised row driver and sequencer for the CIM/CAM array. Successor to the fixed 4-row word-line decoder.
- Generalised to ROWS rows. Adds explicit precharge and word-line pulse timing, multi-row MAC bursts with address wrap, and a start/busy/done handshake.
- Sits between the array controller and the bitcell array. Drives WL, WLB and precharge enable.

Parameters:
- ROWS, 16, number of array rows (power of 2, at least 2)
- AW, $clog2(ROWS), row address width
- PRECH_W, 1, precharge phase length in cycles (at least 1)
- PULSE_W, 2, word-line assertion length in cycles (at least 1)

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-high reset
- cs  in  1  chip select; low aborts any operation and blanks all lines
- start  in  1  operation request; sampled only in IDLE
- mode  in  2  00 write, 01 MAC (WL side), 10 MAC-bar (WLB side), 11 CAM search
- addr  in  AW  first row address
- burst_len  in  AW+1  rows to visit in MAC/MAC-bar; 0 is treated as 1; values above ROWS are clamped to ROWS
- data  in  ROWS  CAM search key
- busy  out  1  high from the cycle after start is accepted until done
- done  out  1  one-cycle pulse at completion
- prech_en  out  1  bitline precharge enable
- WL  out  ROWS  word lines
- WLB  out  ROWS  complementary word lines
- row_idx  out  AW  row currently being driven

Behaviour:
- Reset (async): state IDLE. busy, done, prech_en = 0. WL, WLB, row_idx = 0. All outputs are registered.
- IDLE:
  - On start & cs: latch mode, addr, clamped burst_len and data. Set a phase counter and go to PRECH. busy = 1 from the next cycle.
  - start while busy is ignored; no queueing.
- PRECH:
  - prech_en = 1, WL = WLB = 0, held for PRECH_W cycles, then go to ASSERT.
- ASSERT: prech_en = 0, held for PULSE_W cycles. Lines are driven per latched mode, with oh = one-hot(row_idx):
  - write: WL = oh, WLB = oh
  - MAC: WL = oh, WLB = 0
  - MAC-bar: WL = 0, WLB = oh
  - CAM: WL = key, WLB = ~key
- After ASSERT: decrement the remaining count.
  - If it is nonzero and mode is MAC or MAC-bar: row_idx = (row_idx + 1) mod ROWS (wraps ROWS-1 to 0), then go to PRECH.
  - Otherwise go to DONE.
  - Write and CAM always visit exactly one row.
- DONE: done = 1 for one cycle, busy = 0, lines zero; return to IDLE.
  - A start present in the DONE cycle is ignored; it must be re-presented in IDLE.
- Latency, single row: start sampled at edge 0. prech_en is high for cycles 1..PRECH_W. Lines are driven for the next PULSE_W cycles. done appears at cycle PRECH_W+PULSE_W+1.
- Latency, burst: N rows take N*(PRECH_W+PULSE_W)+1 cycles from start to done.
- Abort: cs low in any state takes effect at the next edge.
  - State returns to IDLE; all outputs go to 0.
  - No done pulse; busy drops.
- Mid-operation reset: async clear to the reset values above; no done pulse.
- Input changes while busy: inputs are latched at start, so mode, addr, burst_len and data changes have no effect.
- Invariants:
  - WL and WLB are never nonzero while prech_en = 1.
  - In MAC/MAC-bar, at most one bit of WL or WLB is set.

Decomposition:
- Shared package cim_pkg:
  - Mode encodings MODE_WRITE, MODE_MAC, MODE_MACB, MODE_CAM.
  - FSM state enum IDLE, PRECH, ASSERT, DONE.
- Sub-module cim_onehot_dec: parametrised AW-to-ROWS one-hot decoder, purely combinational, reusable by the column side.

Test Plan:
- Reset and idle: assert rst mid-run, then idle with cs = 1 → all outputs 0 immediately, busy = 0.
- Write, ROWS=16, addr=5, PRECH_W=1, PULSE_W=2:
  - prech_en high in cycle 1.
  - WL = WLB = 0x0020 in cycles 2-3.
  - done pulse in cycle 4.
- MAC burst with wrap, addr=14, burst_len=4 → WL one-hot visits rows 14, 15, 0, 1, each preceded by a precharge cycle. WLB = 0 throughout; done at cycle 13.
- CAM: data=0xA5C3, mode=11 → WL = 0xA5C3 and WLB = 0x5A3C for 2 cycles, then a single done pulse. burst_len = 7 is ignored.
- Abort and ignored start:
  - Drop cs during row 2 of a 4-row MAC-bar burst → next cycle all lines 0, busy = 0, no done.
  - A start pulsed while busy → no extra operation.
- burst_len edge cases:
  - burst_len = 0 → exactly one row visited.
  - burst_len = 31 with ROWS = 16 → exactly 16 rows visited, done once.
